// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes and controller states.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables/data replication and alignment checking on the
// request side, lane extraction with sign/zero extension on the load side.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata_rep,
   output logic        req_align_err,
   input  logic [31:0] ld_word,
   input  logic [1:0]  ld_addr_lo,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   output logic [31:0] ld_data
);

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
      return uns ? {24'd0, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
      return uns ? {16'd0, h} : {{16{h[15]}}, h};
   endfunction

   always_comb begin
      req_be        = 4'b0000;
      req_wdata_rep = req_wdata;
      req_align_err = 1'b0;
      case (req_size)
         SIZE_BYTE: begin
            req_be        = 4'b0001 << req_addr_lo;
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            req_be        = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            req_wdata_rep = {2{req_wdata[15:0]}};
            req_align_err = req_addr_lo[0];
         end
         SIZE_WORD: begin
            req_be        = 4'b1111;
            req_align_err = |req_addr_lo;
         end
         default: req_align_err = 1'b1;
      endcase
   end

   always_comb begin
      ld_data = '0;
      case (ld_size)
         SIZE_BYTE: ld_data = ext8(ld_word[8*ld_addr_lo +: 8], ld_unsigned);
         SIZE_HALF: ld_data = ext16(ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0], ld_unsigned);
         SIZE_WORD: ld_data = ld_word;
         default:   ld_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: post-reset clear sweep, byte/half/word accesses with error flagging,
// and in-order responses at a fixed READ_LAT of 1 or 2 cycles.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic              init_busy
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;
   logic [31:0]      mem [DEPTH];

   logic             accept;
   logic [IDX_W-1:0] req_idx;
   logic             range_err, align_err, req_err;
   logic [3:0]       req_be;
   logic [31:0]      req_wdata_rep;

   logic             vld_p0;
   logic [31:0]      word_p0;
   logic [1:0]       addr_lo_p0, size_p0;
   logic             uns_p0, err_p0, load_p0;
   logic [31:0]      ld_data, rsp_rdata_c;

   assign accept    = req_valid && req_ready;
   assign req_idx   = req_addr[IDX_W+1:2];
   assign range_err = |(req_addr >> (IDX_W + 2));
   assign req_err   = range_err || align_err;
   assign req_ready = (state == ST_RUN);
   assign init_busy = (state == ST_INIT);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == ST_INIT) begin
         cnt_nxt = cnt + 1'b1;
         if (cnt == IDX_W'(DEPTH - 1))
            state_nxt = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   dmem_lane_align u_align (
      .req_size      (req_size),
      .req_addr_lo   (req_addr[1:0]),
      .req_wdata     (req_wdata),
      .req_be        (req_be),
      .req_wdata_rep (req_wdata_rep),
      .req_align_err (align_err),
      .ld_word       (word_p0),
      .ld_addr_lo    (addr_lo_p0),
      .ld_size       (size_p0),
      .ld_unsigned   (uns_p0),
      .ld_data       (ld_data)
   );

   // Errored stores never reach the array; the sweep owns the write port while initialising.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[cnt] <= '0;
      end else if (accept && req_write && !req_err) begin
         for (int b = 0; b < 4; b++)
            if (req_be[b])
               mem[req_idx][8*b +: 8] <= req_wdata_rep[8*b +: 8];
      end
   end

   // Stage p0: word sampled on the accepting edge, lane selection happens on the way out
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_p0 <= 1'b0;
      else        vld_p0 <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         word_p0    <= mem[req_idx];
         addr_lo_p0 <= req_addr[1:0];
         size_p0    <= req_size;
         uns_p0     <= req_unsigned;
         err_p0     <= req_err;
         load_p0    <= !req_write;
      end
   end

   assign rsp_rdata_c = (load_p0 && !err_p0) ? ld_data : '0;

   // Stage p1: optional extra register for READ_LAT == 2
   if (READ_LAT == 2) begin : g_lat2
      logic        vld_p1;
      logic [31:0] rdata_p1;
      logic        err_p1;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) vld_p1 <= 1'b0;
         else        vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
         rdata_p1 <= rsp_rdata_c;
         err_p1   <= err_p0;
      end

      assign rsp_valid = vld_p1;
      assign rsp_rdata = vld_p1 ? rdata_p1 : '0;
      assign rsp_error = vld_p1 && err_p1;
   end else begin : g_lat1
      assign rsp_valid = vld_p0;
      assign rsp_rdata = vld_p0 ? rsp_rdata_c : '0;
      assign rsp_error = vld_p0 && err_p0;
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: identical stimulus into a READ_LAT=1 and a READ_LAT=2 instance,
// table-driven requests with a per-instance response scoreboard, plus reset/sweep sequences.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   logic        req_ready1, rsp_valid1, rsp_error1, init_busy1;
   logic [31:0] rsp_rdata1;
   logic        req_ready2, rsp_valid2, rsp_error2, init_busy2;
   logic [31:0] rsp_rdata2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          when;
   } exp_t;

   vec_t tbl[$];
   exp_t q1[$], q2[$];
   exp_t e1, e2;

   data_memory_ctrl #(.DEPTH(256), .ADDR_W(32), .READ_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
      .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1), .init_busy(init_busy1)
   );

   data_memory_ctrl #(.DEPTH(256), .ADDR_W(32), .READ_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid2),
      .rsp_rdata(rsp_rdata2), .rsp_error(rsp_error2), .init_busy(init_busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   // Response monitors: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rsp_valid1) begin
         if (q1.size() == 0) chk("lat1_unexpected_rsp", {31'd0, rsp_valid1}, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("lat1_rdata", rsp_rdata1, e1.rdata);
            chk("lat1_err", {31'd0, rsp_error1}, {31'd0, e1.err});
            chk("lat1_cycle", 32'(cyc), 32'(e1.when));
         end
      end else begin
         chk("lat1_idle_rdata", rsp_rdata1, 32'd0);
         chk("lat1_idle_err", {31'd0, rsp_error1}, 32'd0);
      end
      if (rsp_valid2) begin
         if (q2.size() == 0) chk("lat2_unexpected_rsp", {31'd0, rsp_valid2}, 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("lat2_rdata", rsp_rdata2, e2.rdata);
            chk("lat2_err", {31'd0, rsp_error2}, {31'd0, e2.err});
            chk("lat2_cycle", 32'(cyc), 32'(e2.when));
         end
      end else begin
         chk("lat2_idle_rdata", rsp_rdata2, 32'd0);
         chk("lat2_idle_err", {31'd0, rsp_error2}, 32'd0);
      end
   end

   // Called at posedge+1; accepted at the next edge, returns at posedge+1 with valid dropped.
   task automatic issue(input vec_t v);
      exp_t e;
      req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      e.rdata = v.exp_rdata; e.err = v.exp_err;
      e.when = cyc + 1; q1.push_back(e);
      e.when = cyc + 2; q2.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic do_reset();
      q1.delete(); q2.delete();
      reset = 1'b0;
      #2;
      chk("rst_init_busy", {30'd0, init_busy2, init_busy1}, 32'd3);
      chk("rst_req_ready", {30'd0, req_ready2, req_ready1}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid2, rsp_valid1}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_init();
      int n = 0;
      while (n < 1000) begin
         @(negedge clk);
         if (!init_busy1) break;
         chk("init_ready_low", {30'd0, req_ready2, req_ready1}, 32'd0);
         chk("lat2_init_busy", {31'd0, init_busy2}, 32'd1);
         n++;
      end
      chk("init_cycles", 32'(n), 32'd256);
      chk("run_ready", {30'd0, req_ready2, req_ready1}, 32'd3);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q1.size() + q2.size()) != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_outstanding", 32'(q1.size() + q2.size()), 32'd0);
   endtask

   initial begin
      // size codes: 0 byte, 1 half, 2 word, 3 reserved
      tbl.push_back(mk(0, 2'd2, 0, 32'h44, 0, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h3FC, 0, 32'h0, 0));
      tbl.push_back(mk(1, 2'd2, 0, 32'h10, 32'h8899AABB, 32'h0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 32'h10, 0, 32'hFFFFFFBB, 0));
      tbl.push_back(mk(0, 2'd0, 1, 32'h13, 0, 32'h00000088, 0));
      tbl.push_back(mk(0, 2'd1, 0, 32'h12, 0, 32'hFFFF8899, 0));
      tbl.push_back(mk(0, 2'd1, 1, 32'h10, 0, 32'h0000AABB, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h10, 0, 32'h8899AABB, 0));
      tbl.push_back(mk(0, 2'd0, 1, 32'h11, 0, 32'h000000AA, 0));
      tbl.push_back(mk(0, 2'd0, 0, 32'h12, 0, 32'hFFFFFF99, 0));
      tbl.push_back(mk(0, 2'd1, 1, 32'h12, 0, 32'h00008899, 0));
      tbl.push_back(mk(0, 2'd1, 0, 32'h10, 0, 32'hFFFFAABB, 0));
      tbl.push_back(mk(1, 2'd2, 0, 32'h20, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 2'd0, 0, 32'h21, 32'hFFFFFF7F, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h20, 0, 32'h00007F00, 0));
      tbl.push_back(mk(1, 2'd1, 0, 32'h22, 32'hABCD1234, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h20, 0, 32'h12347F00, 0));
      tbl.push_back(mk(0, 2'd0, 0, 32'h21, 0, 32'h0000007F, 0));
      tbl.push_back(mk(1, 2'd2, 0, 32'h30, 32'hCAFEF00D, 32'h0, 0));
      tbl.push_back(mk(1, 2'd1, 0, 32'h31, 32'h0000FFFF, 32'h0, 1));
      tbl.push_back(mk(0, 2'd2, 0, 32'h22, 0, 32'h0, 1));
      tbl.push_back(mk(0, 2'd2, 0, 32'h400, 0, 32'h0, 1));
      tbl.push_back(mk(1, 2'd2, 0, 32'h400, 32'hDEADBEEF, 32'h0, 1));
      tbl.push_back(mk(1, 2'd3, 0, 32'h30, 32'h11111111, 32'h0, 1));
      tbl.push_back(mk(1, 2'd2, 0, 32'h32, 32'h22222222, 32'h0, 1));
      tbl.push_back(mk(0, 2'd1, 0, 32'h33, 0, 32'h0, 1));
      tbl.push_back(mk(0, 2'd3, 0, 32'h30, 0, 32'h0, 1));
      tbl.push_back(mk(0, 2'd2, 0, 32'h30, 0, 32'hCAFEF00D, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h10, 0, 32'h8899AABB, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h20, 0, 32'h12347F00, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h30, 0, 32'hCAFEF00D, 0));

      #3;
      do_reset();
      wait_init();

      foreach (tbl[i]) issue(tbl[i]);
      drain();

      // Reset part-way through the sweep: the sweep must start over from word 0.
      do_reset();
      repeat (100) @(posedge clk);
      #1;
      do_reset();
      wait_init();

      // Two loads in flight, then reset: the dropped responses must never appear.
      issue(mk(0, 2'd2, 0, 32'h10, 0, 32'h0, 0));
      issue(mk(0, 2'd2, 0, 32'h20, 0, 32'h0, 0));
      do_reset();
      wait_init();

      issue(mk(0, 2'd2, 0, 32'h10, 0, 32'h0, 0));
      issue(mk(0, 2'd2, 0, 32'h20, 0, 32'h0, 0));
      issue(mk(0, 2'd2, 0, 32'h30, 0, 32'h0, 0));
      drain();
      repeat (3) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=%0d required=%0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
